// File: rtl/pc_gen.sv
// Fetch-stage program counter: drives the instruction request with a valid/accept
// handshake, buffers early branch redirects, and takes exception flushes immediately.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    input  logic              if_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redir_pend
);

    // STEP is a power of two, so clearing its low bits aligns a target to a fetch slot.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    typedef enum logic {StOff, StRun} state_t;

    state_t            r_state, w_state_d;
    logic [ADDR_W-1:0] r_pc, w_pc_d;
    logic              r_pend, w_pend_d;
    logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_d;

    logic              w_advance;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_flush_tgt;

    assign w_advance    = if_ack & ~stall;
    assign w_branch_tgt = branch_target & ALIGN_MASK;
    assign w_flush_tgt  = flush_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StOff;
            r_pc       <= RESET_VEC;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_pend     <= w_pend_d;
            r_pend_tgt <= w_pend_tgt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_pend_d     = r_pend;
        w_pend_tgt_d = r_pend_tgt;
        case (r_state)
            StOff: w_state_d = StRun;
            StRun: begin
                // Priority: flush, then completed fetch, then buffering a redirect.
                if (flush) begin
                    w_pc_d   = w_flush_tgt;
                    w_pend_d = 1'b0;
                end else if (w_advance) begin
                    if (branch_valid) begin
                        w_pc_d = w_branch_tgt;
                    end else if (r_pend) begin
                        w_pc_d = r_pend_tgt;
                    end else begin
                        w_pc_d = r_pc + STEP_INC;
                    end
                    w_pend_d = 1'b0;
                end else if (branch_valid) begin
                    w_pend_tgt_d = w_branch_tgt;
                    w_pend_d     = 1'b1;
                end
            end
            default: w_state_d = StOff;
        endcase
    end

    assign pc         = r_pc;
    assign ce         = (r_state == StRun);
    assign redir_pend = r_pend;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a reference model queues expected outputs per edge and a
// monitor compares them; a second 16-bit, STEP=2 instance covers narrow-width alignment.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
    } exp_t;

    logic        clk;
    logic        rst, stall, branch_valid, flush, if_ack;
    logic [31:0] branch_target, flush_target;
    logic [31:0] pc;
    logic        ce, redir_pend;

    logic        rst16, stall16, bv16, flush16, ack16;
    logic [15:0] bt16, ft16, pc16;
    logic        ce16, pend16;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // Reference model state
    logic        m_on;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .flush        (flush),
        .flush_target (flush_target),
        .if_ack       (if_ack),
        .pc           (pc),
        .ce           (ce),
        .redir_pend   (redir_pend)
    );

    pc_gen #(.ADDR_W(16), .RESET_VEC(16'h0), .STEP(2)) u_dut16 (
        .clk          (clk),
        .rst          (rst16),
        .stall        (stall16),
        .branch_valid (bv16),
        .branch_target(bt16),
        .flush        (flush16),
        .flush_target (ft16),
        .if_ack       (ack16),
        .pc           (pc16),
        .ce           (ce16),
        .redir_pend   (pend16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [31:0] align4(input logic [31:0] t);
        return (t / 4) * 4;
    endfunction

    // Expected outputs after the coming rising edge, given the inputs now applied.
    task automatic model_edge();
        exp_t e;
        if (!rst) begin
            m_on = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_ptgt = 32'h0;
        end else if (!m_on) begin
            m_on = 1'b1;
        end else if (flush) begin
            m_pc = align4(flush_target);
            m_pend = 1'b0;
        end else if (if_ack && !stall) begin
            if (branch_valid)  m_pc = align4(branch_target);
            else if (m_pend)   m_pc = m_ptgt;
            else               m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (branch_valid) begin
            m_ptgt = align4(branch_target);
            m_pend = 1'b1;
        end
        e.pc = m_pc; e.ce = m_on; e.pend = m_pend;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic a, input logic bv,
                       input logic [31:0] bt, input logic f, input logic [31:0] ft);
        @(negedge clk);
        #1;
        rst = r; stall = s; if_ack = a; branch_valid = bv; branch_target = bt;
        flush = f; flush_target = ft;
        model_edge();
    endtask

    task automatic cyc16(input logic bv, input logic [15:0] bt, input logic f,
                         input logic [15:0] ft, input logic a, input logic [15:0] exp_pc,
                         input string name);
        @(negedge clk);
        #1;
        rst16 = 1'b1; stall16 = 1'b0; ack16 = a; bv16 = bv; bt16 = bt;
        flush16 = f; ft16 = ft;
        @(posedge clk);
        #2;
        chk({name, "_pc"}, {16'h0, pc16}, {16'h0, exp_pc});
        chk({name, "_ce"}, {31'h0, ce16}, 32'h1);
    endtask

    // Monitor: one expected entry per rising edge while the driver is issuing stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("ce", {31'h0, ce}, {31'h0, e.ce});
                chk("redir_pend", {31'h0, redir_pend}, {31'h0, e.pend});
            end
        end
    end

    initial begin
        rst = 1'b0; stall = 1'b0; if_ack = 1'b1; branch_valid = 1'b0; flush = 1'b0;
        branch_target = '0; flush_target = '0;
        rst16 = 1'b0; stall16 = 1'b0; ack16 = 1'b0; bv16 = 1'b0; flush16 = 1'b0;
        bt16 = '0; ft16 = '0;
        m_on = 1'b0; m_pc = '0; m_pend = 1'b0; m_ptgt = '0;

        // Reset held for 5 cycles, then start-up stepping 0, 4, 8, 0xC, 0x10
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        // Stall / ack gating at 0x10
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        // Branch buffering at 0x20, then overwrite of a pending redirect
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        // Flush beats stall, pending redirect and a simultaneous branch
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 32'hBFC00380);
        // Alignment and wrap
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h1003, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'hFFFFFFFC);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0);
        // Async reset between edges with a redirect pending
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h500,  1'b0, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_ce", {31'h0, ce}, 32'h0);
        chk("async_rst_pend", {31'h0, redir_pend}, 32'h0);
        model_edge();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic, including occasional resets and near-top targets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, ft;
            bt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
            ft = $urandom;
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, bt,
                $urandom_range(0, 19) == 0, ft);
        end

        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        // 16-bit, STEP=2 instance
        cyc16(1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 16'h0000, "w16_start");
        cyc16(1'b1, 16'h0005, 1'b0, 16'h0,    1'b1, 16'h0004, "w16_align");
        cyc16(1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 16'h0006, "w16_step");
        cyc16(1'b0, 16'h0,    1'b1, 16'hFFFF, 1'b0, 16'hFFFE, "w16_flush");
        cyc16(1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 16'h0000, "w16_wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
